uart_rx_v2: RTL and testbench

UART_RX_V2 -- requirements
Module: uart_rx_v2

---
 rtl/uart_rx_v2.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_rx_v2.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_v2.sv
// UART receiver: 16x oversampled, majority-voted bits, configurable framing,
// break detection and a first-word-fall-through receive FIFO with sticky overrun.
module uart_rx_v2 #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [15:0]                   baud_div,
  input  logic [3:0]                    data_bits,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop_bits,
  input  logic                          uart_rx,
  output logic [DATA_WIDTH-1:0]         rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_break,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun,
  input  logic                          overrun_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_busy,
  output logic [2:0]                    dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_WIDTH + 3;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK_WAIT
  } state_t;

  state_t                r_state;
  logic                  r_sync1, r_sync2, r_sync_prev;
  logic [15:0]           r_tick_cnt;
  logic [3:0]            r_phase;
  logic                  r_s7, r_s8;
  logic [3:0]            r_nbits;
  logic [1:0]            r_par;
  logic                  r_stop2;
  logic [3:0]            r_bit_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_xor, r_pbit, r_perr, r_ferr;
  logic                  r_wr_en;
  logic [EW-1:0]         r_wr_entry;

  logic [15:0]           w_div_m1;
  logic                  w_tick, w_start, w_s9, w_s15, w_maj, w_par_en;
  logic [3:0]            w_nbits;
  logic [DATA_WIDTH-1:0] w_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync1     <= uart_rx;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  assign w_div_m1 = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
  assign w_tick   = (r_tick_cnt >= w_div_m1);
  assign w_start  = (r_state == IDLE) && r_sync_prev && !r_sync2;
  assign w_s9     = w_tick && (r_phase == 4'd9);
  assign w_s15    = w_tick && (r_phase == 4'd15);
  assign w_maj    = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
  assign w_par_en = (r_par == 2'd1) || (r_par == 2'd2);
  assign w_nbits  = (data_bits >= 4'd5 && data_bits <= 4'(DATA_WIDTH)) ? data_bits
                                                                      : 4'(DATA_WIDTH);
  // Bits shift in from the top, so a short frame sits high in r_shift.
  assign w_data   = r_shift >> (4'(DATA_WIDTH) - r_nbits);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt <= 16'd0;
      r_phase    <= 4'd0;
    end else if (w_start) begin
      r_tick_cnt <= 16'd0;
      r_phase    <= 4'd0;
    end else if (w_tick) begin
      r_tick_cnt <= 16'd0;
      r_phase    <= r_phase + 4'd1;
    end else begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_s7       <= 1'b0;
      r_s8       <= 1'b0;
      r_nbits    <= 4'(DATA_WIDTH);
      r_par      <= 2'd0;
      r_stop2    <= 1'b0;
      r_bit_idx  <= 4'd0;
      r_shift    <= '0;
      r_xor      <= 1'b0;
      r_pbit     <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_entry <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_tick && r_phase == 4'd7) r_s7 <= r_sync2;
      if (w_tick && r_phase == 4'd8) r_s8 <= r_sync2;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state   <= START;
            r_nbits   <= w_nbits;
            r_par     <= parity_mode;
            r_stop2   <= stop_bits;
            r_bit_idx <= 4'd0;
            r_shift   <= '0;
            r_xor     <= 1'b0;
            r_pbit    <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
          end
        end
        START: begin
          if (w_s9 && w_maj) r_state <= IDLE;
          else if (w_s15)    r_state <= DATA;
        end
        DATA: begin
          if (w_s9) begin
            r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
            r_xor   <= r_xor ^ w_maj;
          end else if (w_s15) begin
            if (r_bit_idx == r_nbits - 4'd1) r_state <= w_par_en ? PARITY : STOP1;
            else                             r_bit_idx <= r_bit_idx + 4'd1;
          end
        end
        PARITY: begin
          if (w_s9) begin
            r_pbit <= w_maj;
            r_perr <= (r_xor ^ w_maj) != (r_par == 2'd2);
          end else if (w_s15) begin
            r_state <= STOP1;
          end
        end
        STOP1: begin
          if (w_s9) begin
            if (!w_maj && r_shift == '0 && !r_pbit) begin
              r_wr_en    <= 1'b1;
              r_wr_entry <= {{DATA_WIDTH{1'b0}}, 3'b011};
              r_state    <= BREAK_WAIT;
            end else if (!r_stop2) begin
              r_wr_en    <= 1'b1;
              r_wr_entry <= {w_data, r_perr, r_ferr | !w_maj, 1'b0};
              r_state    <= IDLE;
            end else begin
              r_ferr <= !w_maj;
            end
          end else if (w_s15) begin
            r_state <= STOP2;
          end
        end
        STOP2: begin
          if (w_s9) begin
            r_wr_en    <= 1'b1;
            r_wr_entry <= {w_data, r_perr, r_ferr | !w_maj, 1'b0};
            r_state    <= IDLE;
          end
        end
        BREAK_WAIT: begin
          if (r_sync2) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_busy   = (r_state != IDLE);
  assign dbg_state = r_state;

  // Pop handshake: an entry leaves on any clk where rx_valid && rx_ready;
  // rx_valid never depends on rx_ready, and the head is stable until popped.
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full, w_empty, w_pop, w_push;
  logic [EW-1:0] w_head;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && rx_ready;
  assign w_push  = r_wr_en && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= r_wr_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      overrun <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
      if (r_wr_en && w_full && !w_pop) overrun <= 1'b1;
      else if (overrun_clr)            overrun <= 1'b0;
    end
  end

  assign w_head        = r_mem[r_rptr];
  assign rx_valid      = !w_empty;
  assign fifo_count    = r_count;
  assign rx_data       = w_empty ? '0   : w_head[EW-1:3];
  assign rx_parity_err = w_empty ? 1'b0 : w_head[2];
  assign rx_frame_err  = w_empty ? 1'b0 : w_head[1];
  assign rx_break      = w_empty ? 1'b0 : w_head[0];

endmodule

// File: tb/tb_uart_rx_v2.sv
// Bench for uart_rx_v2: reset checks, a vector table of framed bytes,
// multi-cycle corner sequences, and randomized frames against a frame-level model.
module tb_uart_rx_v2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int EW    = DW + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   baud_div;
  logic [3:0]    data_bits;
  logic [1:0]    parity_mode;
  logic          stop_bits;
  logic          uart_rx;
  logic [DW-1:0] rx_data;
  logic          rx_parity_err, rx_frame_err, rx_break, rx_valid, rx_ready;
  logic          overrun, overrun_clr;
  logic [2:0]    fifo_count;
  logic          rx_busy;
  logic [2:0]    dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];

  uart_rx_v2 #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .data_bits(data_bits),
    .parity_mode(parity_mode), .stop_bits(stop_bits), .uart_rx(uart_rx),
    .rx_data(rx_data), .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_break(rx_break), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .overrun(overrun), .overrun_clr(overrun_clr), .fifo_count(fifo_count),
    .rx_busy(rx_busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          div;
    logic [3:0]  bits;
    logic [1:0]  par;
    logic        stop;
    logic [8:0]  data;
    bit          flip;
    bit          slow;
    logic [EW-1:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int eff_div();
    return (baud_div == 16'd0) ? 1 : int'(baud_div);
  endfunction

  function automatic int eff_bits(input logic [3:0] b);
    return (b >= 4'd5 && int'(b) <= DW) ? int'(b) : DW;
  endfunction

  function automatic logic [DW-1:0] mask_data(input logic [8:0] data, input int nb);
    logic [DW-1:0] d;
    for (int i = 0; i < DW; i++) d[i] = (i < nb) ? data[i] : 1'b0;
    return d;
  endfunction

  // Parity bit as it appears on the line; flip deliberately corrupts it.
  function automatic logic par_bit(input logic [DW-1:0] d, input logic [1:0] par, input bit flip);
    int ones = 0;
    logic p;
    for (int i = 0; i < DW; i++) ones += int'(d[i]);
    p = (par == 2'd2) ? ((ones % 2) == 0) : ((ones % 2) == 1);
    return p ^ flip;
  endfunction

  function automatic logic [EW-1:0] model(input logic [3:0] bits, input logic [1:0] par,
                                          input logic [8:0] data, input bit flip, input bit slow);
    int nb = eff_bits(bits);
    logic [DW-1:0] d = mask_data(data, nb);
    bit pen = (par == 2'd1) || (par == 2'd2);
    logic pb = pen ? par_bit(d, par, flip) : 1'b0;
    int ones = 0;
    bit perr;
    for (int i = 0; i < DW; i++) ones += int'(d[i]);
    perr = pen && (((ones + int'(pb)) % 2) != ((par == 2'd2) ? 1 : 0));
    if (slow && d == '0 && !pb) return {{DW{1'b0}}, 3'b011};
    return {d, perr, slow, 1'b0};
  endfunction

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (16 * eff_div()) @(negedge clk);
  endtask

  task automatic send_frame(input int div, input logic [3:0] bits, input logic [1:0] par,
                            input logic stop, input logic [8:0] data, input bit flip, input bit slow);
    int nb;
    logic [DW-1:0] d;
    baud_div    = 16'(div);
    data_bits   = bits;
    parity_mode = par;
    stop_bits   = stop;
    nb = eff_bits(bits);
    d  = mask_data(data, nb);
    @(negedge clk);
    drive_bit(1'b0);
    data_bits   = 4'($urandom);
    parity_mode = 2'($urandom);
    stop_bits   = 1'($urandom);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (par == 2'd1 || par == 2'd2) drive_bit(par_bit(d, par, flip));
    drive_bit(!slow);
    if (stop) drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  task automatic pop_check(input string name, input logic [EW-1:0] exp);
    int n = 0;
    while (!rx_valid && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, 32'(rx_valid), 32'd1);
    if (rx_valid) begin
      check({name, "_data"}, 32'(rx_data), 32'(exp[EW-1:3]));
      check({name, "_perr"}, 32'(rx_parity_err), 32'(exp[2]));
      check({name, "_ferr"}, 32'(rx_frame_err), 32'(exp[1]));
      check({name, "_brk"}, 32'(rx_break), 32'(exp[0]));
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
    end
  endtask

  task automatic random_round(input int r);
    int k, div;
    logic [3:0] bits;
    logic [1:0] par;
    logic stop;
    logic [8:0] data;
    bit flip, slow;
    k = $urandom_range(1, 3);
    for (int j = 0; j < k; j++) begin
      div  = $urandom_range(0, 3);
      bits = 4'($urandom_range(0, 15));
      par  = 2'($urandom_range(0, 3));
      stop = 1'($urandom_range(0, 1));
      data = 9'($urandom);
      if ($urandom_range(0, 7) == 0) data = 9'd0;
      flip = ($urandom_range(0, 3) == 0);
      slow = ($urandom_range(0, 4) == 0);
      send_frame(div, bits, par, stop, data, flip, slow);
      exp_q.push_back(model(bits, par, data, flip, slow));
    end
    check($sformatf("rnd%0d_count", r), 32'(fifo_count), 32'(k));
    while (exp_q.size() > 0) pop_check($sformatf("rnd%0d", r), exp_q.pop_front());
    check($sformatf("rnd%0d_empty", r), 32'(rx_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{27, 4'd8,  2'd0, 1'b0, 9'h0A5, 1'b0, 1'b0, {8'hA5, 3'b000}};
    vecs[1] = '{4,  4'd7,  2'd1, 1'b1, 9'h035, 1'b1, 1'b0, {8'h35, 3'b100}};
    vecs[2] = '{4,  4'd8,  2'd0, 1'b0, 9'h03C, 1'b0, 1'b1, {8'h3C, 3'b010}};
    vecs[3] = '{2,  4'd5,  2'd2, 1'b0, 9'h0FF, 1'b0, 1'b0, {8'h1F, 3'b000}};
    vecs[4] = '{3,  4'd4,  2'd3, 1'b1, 9'h0C3, 1'b0, 1'b0, {8'hC3, 3'b000}};
    vecs[5] = '{0,  4'd6,  2'd1, 1'b0, 9'h02A, 1'b0, 1'b0, {8'h2A, 3'b000}};
    vecs[6] = '{2,  4'd15, 2'd2, 1'b0, 9'h000, 1'b1, 1'b0, {8'h00, 3'b100}};
    vecs[7] = '{2,  4'd8,  2'd1, 1'b0, 9'h000, 1'b0, 1'b1, {8'h00, 3'b011}};
    vecs[8] = '{3,  4'd9,  2'd0, 1'b1, 9'h081, 1'b0, 1'b1, {8'h81, 3'b010}};

    rst = 1'b1; uart_rx = 1'b0; rx_ready = 1'b0; overrun_clr = 1'b0;
    baud_div = 16'd4; data_bits = 4'd8; parity_mode = 2'd0; stop_bits = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_flags", 32'({rx_parity_err, rx_frame_err, rx_break}), 32'd0);

    // Line low through and after reset must not look like a start bit.
    rst = 1'b0;
    repeat (3 * 64) @(negedge clk);
    check("lowrst_busy", 32'(rx_busy), 32'd0);
    uart_rx = 1'b1;
    repeat (2 * 64) @(negedge clk);
    check("lowrst_count", 32'(fifo_count), 32'd0);

    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].div, vecs[i].bits, vecs[i].par, vecs[i].stop,
                 vecs[i].data, vecs[i].flip, vecs[i].slow);
      check($sformatf("vec%0d_count", i), 32'(fifo_count), 32'd1);
      pop_check($sformatf("vec%0d", i), vecs[i].exp);
      check($sformatf("vec%0d_popped", i), 32'(rx_valid), 32'd0);
    end

    // Line held low for 20 bit times: one break entry, busy until release.
    baud_div = 16'd4; data_bits = 4'd8; parity_mode = 2'd0; stop_bits = 1'b0;
    uart_rx = 1'b0;
    repeat (20 * 64) @(negedge clk);
    check("brk_busy_low", 32'(rx_busy), 32'd1);
    check("brk_count", 32'(fifo_count), 32'd1);
    uart_rx = 1'b1;
    repeat (6) @(negedge clk);
    check("brk_busy_rel", 32'(rx_busy), 32'd0);
    pop_check("brk", {{DW{1'b0}}, 3'b011});
    check("brk_after", 32'(fifo_count), 32'd0);

    for (int v = 1; v <= 5; v++) send_frame(4, 4'd8, 2'd0, 1'b0, 9'(v), 1'b0, 1'b0);
    check("ovr_count", 32'(fifo_count), 32'(DEPTH));
    check("ovr_flag", 32'(overrun), 32'd1);
    for (int v = 1; v <= 4; v++) pop_check($sformatf("ovr_pop%0d", v), {8'(v), 3'b000});
    check("ovr_empty", 32'(rx_valid), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr_clr", 32'(overrun), 32'd0);

    // Short glitch of 4 oversample ticks is a false start.
    baud_div = 16'd4;
    uart_rx = 1'b0;
    repeat (16) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * 64) @(negedge clk);
    check("glitch_count", 32'(fifo_count), 32'd0);
    check("glitch_busy", 32'(rx_busy), 32'd0);

    // Reset in the middle of a byte discards it.
    uart_rx = 1'b0;
    repeat (64) @(negedge clk);
    uart_rx = 1'b1;
    repeat (64) @(negedge clk);
    uart_rx = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_busy_before", 32'(rx_busy), 32'd1);
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (3 * 64) @(negedge clk);
    check("mid_count", 32'(fifo_count), 32'd0);
    check("mid_busy", 32'(rx_busy), 32'd0);
    check("mid_valid", 32'(rx_valid), 32'd0);
    send_frame(4, 4'd8, 2'd0, 1'b0, 9'h05A, 1'b0, 1'b0);
    pop_check("clean5a", {8'h5A, 3'b000});

    for (int r = 0; r < 5; r++) random_round(r);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
